// File: rtl/pe_pkg.sv
// Shared types and widths for the PE operand feeder and its FIFO.
package pe_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/pe_fifo.sv
// Operand-pair FIFO. Read data is presented from the head entry, so a pair
// written this cycle only becomes poppable once level reflects it (no bypass).
module pe_fifo
   import pe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2 * DATA_W,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = level_q;

   // Next pointers, storage and occupancy; pointers wrap naturally (DEPTH is a power of two).
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/pe_operand_feeder.sv
// Feeds buffered operand pairs to a MAC PE in runs of a programmed length.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; FIFO keeps accepting pairs
// ST_RUN  | popping one pair per cycle while data and count remain
// ST_DONE | single-cycle completion (done=1), then back to IDLE
module pe_operand_feeder
   import pe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LEN_W = 8,
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              pe_valid,
   output logic [DATA_W-1:0] pe_a,
   output logic [DATA_W-1:0] pe_b,
   output logic              busy,
   output logic              done,
   output logic [LVL_W-1:0]  level
);

   feeder_state_e           state_q, state_d;
   logic [LEN_W-1:0]        remaining_q, remaining_d;
   logic                    pe_valid_q, pe_valid_d;
   logic [DATA_W-1:0]       pe_a_q, pe_a_d;
   logic [DATA_W-1:0]       pe_b_q, pe_b_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [2*DATA_W-1:0]     fifo_rdata;
   logic                    push;
   logic                    pop;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == ST_RUN) && !fifo_empty && (remaining_q != '0);

   pe_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({in_a, in_b}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state, run counter and issue-register logic.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pe_valid_d  = 1'b0;
      pe_a_d      = pe_a_q;
      pe_b_d      = pe_b_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               remaining_d = len;
               state_d     = (len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (pop) begin
               remaining_d = remaining_q - LEN_W'(1);
               pe_valid_d  = 1'b1;
               pe_a_d      = fifo_rdata[2*DATA_W-1:DATA_W];
               pe_b_d      = fifo_rdata[DATA_W-1:0];
               if (remaining_q == LEN_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // done and busy are registered copies of the upcoming state decode.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // FSM and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         pe_valid_q  <= 1'b0;
         pe_a_q      <= '0;
         pe_b_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         pe_valid_q  <= pe_valid_d;
         pe_a_q      <= pe_a_d;
         pe_b_q      <= pe_b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pe_valid = pe_valid_q;
   assign pe_a     = pe_a_q;
   assign pe_b     = pe_b_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: doc/pe_operand_feeder.md
PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 Parameter LEN_W, default 8, width of the run-length count.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host offers an operand pair.
REQ-006 in_ready  output  1  feeder accepts the pair this cycle.
REQ-007 in_a, in_b  input  8 each  operand pair from host.
REQ-008 start  input  1  one-cycle pulse; begin a run.
REQ-009 len  input  LEN_W  pairs to issue in the run; sampled on start.
REQ-010 pe_valid  output  1  one-cycle issue strobe to the MAC PE.
REQ-011 pe_a, pe_b  output  8 each  operands to the MAC PE, valid with pe_valid.
REQ-012 busy  output  1  high while state is RUN.
REQ-013 done  output  1  one-cycle pulse at run completion.
REQ-014 level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-015 Push occurs on a cycle with in_valid && in_ready; in_ready = (level != DEPTH), independent of in_valid and FSM state.
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the pop of the final pair; DONE->IDLE unconditionally after one cycle.
REQ-017 On start in IDLE, remaining counter loads len; if len==0, FSM goes IDLE->DONE directly and no pe_valid is issued.
REQ-018 start while in RUN or DONE is ignored; len is not resampled.
REQ-019 Pop occurs in RUN when level != 0 and remaining != 0; at most one pop per cycle; remaining decrements by 1 per pop.
REQ-020 pe_valid, pe_a, pe_b are registered: a pop in cycle t drives pe_valid=1 with that pair in cycle t+1; pe_valid is 0 in every other cycle.
REQ-021 pe_a/pe_b hold their last issued values while pe_valid=0.
REQ-022 done is high exactly in the DONE-state cycle, which is the same cycle as the final pe_valid (or the cycle after start when len==0).
REQ-023 busy = (state == RUN).
REQ-024 FIFO empty in RUN: no pop, no pe_valid; the run stalls until data arrives, with no timeout.
REQ-025 Simultaneous push and pop: both take effect; level is unchanged; FIFO order is preserved.
REQ-026 No bypass: a pair pushed in cycle t is poppable no earlier than cycle t+1.
REQ-027 FIFO read/write pointers wrap modulo DEPTH; level saturates neither high nor low because in_ready and the pop condition gate it.
REQ-028 Pairs left in the FIFO after a run remain for the next run.

Reset
REQ-029 rst=0 asynchronously forces state=IDLE, level=0, pointers=0, remaining=0, pe_valid=0, pe_a=0, pe_b=0, done=0, busy=0.
REQ-030 Reset asserted mid-run aborts the run: FIFO contents are discarded, no done pulse is produced, and outputs return to their reset values immediately.
REQ-031 in_ready=1 during and after reset.

Structure
REQ-032 Shared package pe_pkg holds DATA_W=8, ACC_W=16, and the feeder state enum type.
REQ-033 The FIFO is a separate sub-module, pe_fifo (parameters DEPTH, WIDTH=2*DATA_W), with push/pop/level ports and the same clk/rst.
REQ-034 The FSM, remaining counter, and output registers live in pe_operand_feeder.

Verification
REQ-035 Push (2,3),(4,5); start len=2 -> pe_valid on 2 consecutive cycles with (2,3) then (4,5); done coincides with the second beat; a MAC PE downstream reaches acc=26.
REQ-036 Start len=3 with an empty FIFO; push one pair every 3rd cycle -> exactly 3 pe_valid beats, each 1 cycle after its push-enabled pop; busy stays high throughout; done on the third beat.
REQ-037 Push 4 pairs with no run -> level=4, in_ready=0; a 5th in_valid is not accepted; start len=1 -> level=3 and in_ready=1 on the cycle after the pop.
REQ-038 Start len=0 -> done 1 cycle later, no pe_valid; a start issued during RUN changes neither remaining nor the beat count.
REQ-039 FIFO full, RUN, in_valid held high -> level stays at DEPTH-1/DEPTH per the push/pop rules; issue order matches push order across pointer wrap (12 pairs pushed and popped).
REQ-040 Assert rst mid-run after 1 of 3 beats -> pe_valid=0, level=0, state IDLE immediately, no done; after release, push (7,1) and start len=1 -> single beat (7,1).
